// File: rtl/trig_ringbuffer_if.sv
// trig_ringbuffer_if
//   Sample-in and window-out stream bundle for trig_ringbuffer.
//   Write side : wr_en, din, trig   (driven by the ADC deserialiser)
//   Read side  : rd_valid, rd_data, rd_first, rd_last (to readout), rd_ready (from readout)
//   modport slave  : the ring buffer
//   modport master : the producer/consumer around it
interface trig_ringbuffer_if #(
  parameter int DW = 28
);
  logic          wr_en;
  logic [DW-1:0] din;
  logic          trig;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_first;
  logic          rd_last;

  modport master (
    output wr_en, din, trig, rd_ready,
    input  rd_valid, rd_data, rd_first, rd_last
  );

  modport slave (
    input  wr_en, din, trig, rd_ready,
    output rd_valid, rd_data, rd_first, rd_last
  );
endinterface

// File: rtl/trig_ringbuffer.sv
// trig_ringbuffer
//   Circular sample memory that captures PRE samples before and POST samples
//   from an external trigger, freezes, and streams the window out.
//   Ports:
//     sysclk       single clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          trig_ringbuffer_if.slave (sample in, window out)
//     trig_addr    memory address of the trigger sample
//     armed        state is ARMED
//     busy         state is POST or READOUT
//     missed_trig  saturating count of triggers seen outside ARMED
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_FILL    | collecting PRE history samples after reset/readout
//   ST_ARMED   | history valid, waiting for a trigger with wr_en
//   ST_POST    | collecting the remaining POST-1 samples
//   ST_READOUT | memory frozen, window streamed over rd_* handshake
module trig_ringbuffer #(
  parameter int SIZE  = 12,
  parameter int WIDTH = 14,
  parameter int NCH   = 2,
  parameter int PRE   = 16,
  parameter int POST  = 48
) (
  input  logic                sysclk,
  input  logic                rst_n,
  trig_ringbuffer_if.slave    bus,
  output logic [SIZE-1:0]     trig_addr,
  output logic                armed,
  output logic                busy,
  output logic [7:0]          missed_trig
);

  localparam int DW    = NCH * WIDTH;
  localparam int DEPTH = 1 << SIZE;
  localparam int NWIN  = PRE + POST;

  localparam logic [SIZE:0]   ONE_W   = (SIZE+1)'(1);
  localparam logic [SIZE-1:0] ONE_A   = SIZE'(1);
  localparam logic [SIZE:0]   PRE_M1  = (SIZE+1)'(PRE - 1);
  localparam logic [SIZE:0]   POST_M1 = (SIZE+1)'(POST - 1);
  localparam logic [SIZE:0]   NWIN_W  = (SIZE+1)'(NWIN);
  localparam logic [SIZE-1:0] PRE_A   = SIZE'(PRE);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_READOUT
  } state_t;

  state_t state, state_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [SIZE-1:0] wptr;
  logic [SIZE:0]   fill_cnt;
  logic [SIZE:0]   post_cnt;

  logic wr_acc;
  logic trig_hit;
  logic trig_miss;

  // read engine: address generator, registered memory read, 2-entry skid
  logic [SIZE-1:0] rd_addr;
  logic [SIZE:0]   issue_left;
  logic            issue;
  logic            mq_valid;
  logic            mq_first;
  logic            mq_last;
  logic [DW-1:0]   mq_data;
  logic [DW-1:0]   sk_data [2];
  logic [1:0]      sk_first;
  logic [1:0]      sk_last;
  logic            sk_wp;
  logic            sk_rp;
  logic [1:0]      sk_cnt;
  logic [2:0]      occ;
  logic            push;
  logic            pop;
  logic            done;

  assign wr_acc    = bus.wr_en && (state != ST_READOUT);
  assign trig_hit  = bus.wr_en && bus.trig && (state == ST_ARMED);
  assign trig_miss = bus.wr_en && bus.trig && (state != ST_ARMED);

  assign push = mq_valid;
  assign pop  = bus.rd_valid && bus.rd_ready;
  assign done = pop && bus.rd_last;

  // Skid occupancy one cycle ahead, counting the word already in the read
  // register; a new read is only launched if it is guaranteed a slot even
  // when the consumer stalls next cycle.
  assign occ   = {1'b0, sk_cnt} + {2'b00, mq_valid} - {2'b00, pop};
  assign issue = (state == ST_READOUT) && (issue_left != '0) && (occ <= 3'd1);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_FILL: begin
        if (PRE == 0)                              state_d = ST_ARMED;
        else if (wr_acc && (fill_cnt == PRE_M1))   state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_hit) state_d = (POST == 1) ? ST_READOUT : ST_POST;
      end
      ST_POST: begin
        if (wr_acc && (post_cnt == POST_M1)) state_d = ST_READOUT;
      end
      ST_READOUT: begin
        if (done) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      trig_addr   <= '0;
      missed_trig <= '0;
      armed       <= (PRE == 0);
      busy        <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE_A;

      if ((state == ST_READOUT) && done)
        fill_cnt <= '0;
      else if ((state == ST_FILL) && wr_acc)
        fill_cnt <= fill_cnt + ONE_W;

      if (trig_hit) begin
        trig_addr <= wptr;
        post_cnt  <= ONE_W;
      end else if ((state == ST_POST) && wr_acc) begin
        post_cnt  <= post_cnt + ONE_W;
      end

      if (trig_miss && (missed_trig != 8'hFF))
        missed_trig <= missed_trig + 8'd1;

      // decoded from the next state so the flops line up with state itself
      armed <= (state_d == ST_ARMED);
      busy  <= (state_d == ST_POST) || (state_d == ST_READOUT);
    end
  end

  // Window start is derived from wptr at the trigger so it is ready even
  // when POST=1 sends the block straight from ARMED to READOUT.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      issue_left <= '0;
      mq_valid   <= 1'b0;
      mq_first   <= 1'b0;
      mq_last    <= 1'b0;
    end else begin
      if (trig_hit) begin
        rd_addr    <= wptr - PRE_A;
        issue_left <= NWIN_W;
      end else if (issue) begin
        rd_addr    <= rd_addr + ONE_A;
        issue_left <= issue_left - ONE_W;
      end
      mq_valid <= issue;
      mq_first <= issue && (issue_left == NWIN_W);
      mq_last  <= issue && (issue_left == ONE_W);
    end
  end

  // Memory and its read register carry no reset; contents survive reset.
  // Writes and reads never overlap because writes stop in READOUT.
  always_ff @(posedge sysclk) begin
    if (wr_acc) mem[wptr] <= bus.din;
    if (issue)  mq_data   <= mem[rd_addr];
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) sk_data[i] <= '0;
      sk_first <= '0;
      sk_last  <= '0;
      sk_wp    <= 1'b0;
      sk_rp    <= 1'b0;
      sk_cnt   <= '0;
    end else begin
      if (push) begin
        sk_data[sk_wp]  <= mq_data;
        sk_first[sk_wp] <= mq_first;
        sk_last[sk_wp]  <= mq_last;
        sk_wp           <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      unique case ({push, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

  assign bus.rd_valid = (sk_cnt != 2'd0);
  assign bus.rd_data  = sk_data[sk_rp];
  assign bus.rd_first = bus.rd_valid && sk_first[sk_rp];
  assign bus.rd_last  = bus.rd_valid && sk_last[sk_rp];

endmodule

// File: tb/tb_trig_ringbuffer.sv
// tb_trig_ringbuffer
//   Bench for trig_ringbuffer with SIZE=4, WIDTH=8, NCH=2, PRE=3, POST=5.
//   A reference model tracks accepted samples as a history list and pushes
//   each expected window into a scoreboard; a separate monitor pops and
//   compares whenever the DUT presents a word.
module tb_trig_ringbuffer;
  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int NCH   = 2;
  localparam int PRE   = 3;
  localparam int POST  = 5;
  localparam int DW    = NCH * WIDTH;
  localparam int NWIN  = PRE + POST;
  localparam int DEPTH = 1 << SIZE;

  localparam int M_FILL  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_RO    = 3;

  logic            sysclk;
  logic            rst_n;
  logic [SIZE-1:0] trig_addr;
  logic            armed;
  logic            busy;
  logic [7:0]      missed_trig;

  trig_ringbuffer_if #(.DW(DW)) bif ();

  trig_ringbuffer #(
    .SIZE(SIZE), .WIDTH(WIDTH), .NCH(NCH), .PRE(PRE), .POST(POST)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .bus         (bif),
    .trig_addr   (trig_addr),
    .armed       (armed),
    .busy        (busy),
    .missed_trig (missed_trig)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int vec  = 0;
  int errs = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_hist[$];
  int m_mode   = M_FILL;
  int m_wcnt   = 0;
  int m_fill   = 0;
  int m_posts  = 0;
  int m_taddr  = 0;
  int m_missed = 0;
  int m_age    = 0;
  int m_xfer   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // The window is simply the last PRE+POST accepted samples.
  function automatic void enter_ro();
    int base;
    base = m_hist.size() - NWIN;
    for (int i = 0; i < NWIN; i++)
      sb.push_back('{d: m_hist[base + i], f: (i == 0), l: (i == NWIN - 1)});
    m_mode = M_RO;
    m_age  = 0;
    m_xfer = 0;
  endfunction

  // Reference model: compares current status, then advances on the inputs
  // that the next rising edge will see.
  always @(negedge sysclk) begin : model
    logic acc;
    if (!rst_n) begin
      chk("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
      chk("rst_rd_data", 32'(bif.rd_data), 32'd0);
      chk("rst_armed", 32'(armed), 32'(PRE == 0));
      chk("rst_missed", 32'(missed_trig), 32'd0);
      chk("rst_trig_addr", 32'(trig_addr), 32'd0);
      m_hist.delete();
      m_mode = M_FILL; m_wcnt = 0; m_fill = 0; m_posts = 0;
      m_taddr = 0; m_missed = 0; m_age = 0; m_xfer = 0;
    end else begin
      chk("armed", 32'(armed), 32'(m_mode == M_ARMED));
      chk("busy", 32'(busy), 32'(m_mode == M_POST || m_mode == M_RO));
      chk("trig_addr", 32'(trig_addr), 32'(m_taddr));
      chk("missed_trig", 32'(missed_trig), 32'(m_missed));
      chk("rd_valid", 32'(bif.rd_valid), 32'(m_mode == M_RO && m_age >= 2));

      acc = bif.wr_en && (m_mode != M_RO);
      if (bif.wr_en && bif.trig && m_mode != M_ARMED && m_missed < 255) m_missed++;
      if (acc) begin
        m_hist.push_back(bif.din);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
      end
      case (m_mode)
        M_FILL: begin
          if (PRE == 0) m_mode = M_ARMED;
          else if (acc) begin
            m_fill++;
            if (m_fill >= PRE) m_mode = M_ARMED;
          end
        end
        M_ARMED: begin
          if (bif.wr_en && bif.trig) begin
            m_taddr = m_wcnt % DEPTH;
            m_posts = 1;
            if (m_posts == POST) enter_ro();
            else m_mode = M_POST;
          end
        end
        M_POST: begin
          if (acc) begin
            m_posts++;
            if (m_posts == POST) enter_ro();
          end
        end
        default: begin
          if (m_age >= 2 && bif.rd_ready) begin
            m_xfer++;
            if (m_xfer == NWIN) begin
              m_mode = M_FILL;
              m_fill = 0;
            end
          end
          m_age++;
        end
      endcase
      if (acc) m_wcnt++;
    end
  end

  // Monitor: every presented word must match the scoreboard head; it is
  // consumed only on a handshake, so stalls check that the word holds.
  always @(negedge sysclk) begin : monitor
    if (!rst_n) begin
      sb.delete();
    end else if (bif.rd_valid) begin
      if (sb.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_word: got data 0x%0h, expected no word", bif.rd_data);
      end else begin
        chk("rd_data", 32'(bif.rd_data), 32'(sb[0].d));
        chk("rd_first", 32'(bif.rd_first), 32'(sb[0].f));
        chk("rd_last", 32'(bif.rd_last), 32'(sb[0].l));
        if (bif.rd_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic we, input logic [DW-1:0] d, input logic tg, input logic rdy);
    bif.wr_en    = we;
    bif.din      = d;
    bif.trig     = tg;
    bif.rd_ready = rdy;
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    bif.wr_en = 1'b0; bif.din = '0; bif.trig = 1'b0; bif.rd_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input logic we, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (m_mode == M_RO && n < 100) begin
      step(we, d, 1'b0, 1'b1);
      n++;
    end
    if (m_mode == M_RO) begin
      vec++;
      errs++;
      $display("FAIL drain_timeout: readout still active after %0d cycles, expected done", n);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit pat [10];
    int idx;
    int n;
    logic r;
    pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

    rst_n = 1'b0;
    bif.wr_en = 1'b0; bif.din = '0; bif.trig = 1'b0; bif.rd_ready = 1'b1;
    do_reset();

    // basic capture: trigger on sample 10
    for (int k = 0; k < 20; k++) step(1'b1, DW'(k), (k == 10), 1'b1);
    drain(1'b0, '0);
    chk("s1_trig_addr", 32'(trig_addr), 32'd10);
    step(1'b1, 16'h0101, 1'b0, 1'b1);
    step(1'b1, 16'h0202, 1'b0, 1'b1);
    chk("s1_armed_after_2", 32'(armed), 32'd0);
    step(1'b1, 16'h0303, 1'b0, 1'b1);
    chk("s1_armed_after_3", 32'(armed), 32'd1);

    // wrap-around: trigger on sample 17 lands at address 1
    do_reset();
    for (int k = 0; k < 30; k++) step(1'b1, DW'(k), (k == 17), 1'b1);
    drain(1'b0, '0);
    chk("s2_trig_addr", 32'(trig_addr), 32'd1);

    // early and missed triggers
    do_reset();
    step(1'b1, 16'd100, 1'b1, 1'b1);
    step(1'b0, 16'd0,   1'b1, 1'b1);
    step(1'b1, 16'd101, 1'b0, 1'b1);
    step(1'b1, 16'd102, 1'b0, 1'b1);
    step(1'b1, 16'd103, 1'b0, 1'b1);
    step(1'b1, 16'd104, 1'b1, 1'b1);
    step(1'b1, 16'd105, 1'b1, 1'b1);
    step(1'b1, 16'd106, 1'b1, 1'b1);
    step(1'b1, 16'd107, 1'b0, 1'b1);
    step(1'b1, 16'd108, 1'b0, 1'b1);
    step(1'b1, 16'd109, 1'b1, 1'b1);
    drain(1'b0, '0);
    chk("s3_missed", 32'(missed_trig), 32'd4);
    chk("s3_trig_addr", 32'(trig_addr), 32'd4);

    // backpressure with frozen memory
    for (int k = 0; k < 8; k++) step(1'b1, DW'(16'h0040 + k), (k == 3), 1'b1);
    idx = 0;
    n = 0;
    while (m_mode == M_RO && n < 100) begin
      r = 1'b1;
      if (bif.rd_valid && idx < 10) begin
        r = pat[idx];
        idx++;
      end
      step(1'b1, 16'hFFFF, 1'b0, r);
      n++;
    end
    chk("s4_readout_done", 32'(m_mode == M_RO), 32'd0);

    // reset mid-readout after the third transfer
    for (int k = 0; k < 8; k++) step(1'b1, DW'(16'h0050 + k), (k == 0 || k == 3), 1'b1);
    n = 0;
    while (m_xfer < 3 && n < 40) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("s5_reached_3_xfers", 32'(m_xfer), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("s5_valid_in_reset", 32'(bif.rd_valid), 32'd0);
    chk("s5_missed_in_reset", 32'(missed_trig), 32'd0);
    chk("s5_busy_in_reset", 32'(busy), 32'd0);
    @(posedge sysclk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, DW'(16'h0060 + k), 1'b0, 1'b1);
    chk("s5_armed_after_3", 32'(armed), 32'd1);

    // saturation: continuous triggers over repeated windows
    for (int k = 0; k < 420; k++) step(1'b1, DW'($urandom), 1'b1, 1'b1);
    chk("s6_missed_sat", 32'(missed_trig), 32'd255);
    drain(1'b0, '0);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(3) != 0), DW'($urandom), ($urandom_range(9) == 0),
           ($urandom_range(2) != 0));
    drain(1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
